// File: rtl/dungeon_pkg.sv
// Shared types for the dungeon game core: room codes, direction indices and
// the navigability test used by the room FSM.
package dungeon_pkg;

    typedef enum logic [3:0] {
        ENTRY   = 4'd0,
        HALL    = 4'd1,
        ARMORY  = 4'd2,
        RIVER   = 4'd3,
        KEYRM   = 4'd4,
        GATE    = 4'd5,
        DEN     = 4'd6,
        WIN_RM  = 4'd7,
        GRAVE   = 4'd8,
        DEAD_RM = 4'd9
    } room_t;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    // Rooms in which the player may request a move.
    function automatic logic is_navigable(room_t r);
        return r inside {ENTRY, HALL, ARMORY, RIVER, KEYRM, GATE};
    endfunction

endpackage

// File: rtl/item_fsm.sv
// One collectible item: granted on the edge after its room is occupied,
// optionally lost on the edge after the player passes through the grave.
module item_fsm
    import dungeon_pkg::*;
#(
    parameter room_t GRANT_ROOM     = ARMORY,
    parameter bit    CLEAR_ON_DEATH = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  room_t room,
    output logic  held
);

    typedef enum logic {EMPTY, HELD} item_state_t;

    item_state_t state, state_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        if (room == GRANT_ROOM)
            state_next = HELD;
        else if (CLEAR_ON_DEATH && room == GRAVE)
            state_next = EMPTY;
    end

    assign held = (state == HELD);

endmodule

// File: rtl/dungeon_game.sv
// Game core: Moore room FSM over the ten-room map, lives counter with
// respawn, saturating move counter with optional forced-death limit.
module dungeon_game
    import dungeon_pkg::*;
#(
    parameter  int LIVES      = 3,
    parameter  int MOVE_LIMIT = 0,
    localparam int LW = $clog2(LIVES + 1),
    localparam int MW = ($clog2(MOVE_LIMIT + 1) > 1) ? $clog2(MOVE_LIMIT + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          N,
    input  logic          S,
    input  logic          E,
    input  logic          W,
    output room_t         curr_room,
    output logic          has_sword,
    output logic          has_key,
    output logic [LW-1:0] lives_left,
    output logic [MW-1:0] moves,
    output logic          WIN,
    output logic          DIE
);

    room_t         room_q, room_d, target;
    logic [LW-1:0] lives_q, lives_d;
    logic [MW-1:0] moves_q, moves_d;
    logic [3:0]    dir;
    logic          door_ok;
    logic          limit_hit;

    assign dir[DIR_N] = N;
    assign dir[DIR_S] = S;
    assign dir[DIR_E] = E;
    assign dir[DIR_W] = W;

    assign limit_hit = (MOVE_LIMIT > 0) && (moves_q == MW'(MOVE_LIMIT));

    // Door lookup; only consulted when exactly one direction is requested.
    always_comb begin
        target  = room_q;
        door_ok = 1'b0;
        case (room_q)
            ENTRY:  if (dir[DIR_E]) begin target = HALL; door_ok = 1'b1; end
            HALL: begin
                if (dir[DIR_W])      begin target = ENTRY;  door_ok = 1'b1; end
                else if (dir[DIR_N]) begin target = ARMORY; door_ok = 1'b1; end
                else if (dir[DIR_S]) begin target = RIVER;  door_ok = 1'b1; end
            end
            ARMORY: if (dir[DIR_S]) begin target = HALL; door_ok = 1'b1; end
            RIVER: begin
                if (dir[DIR_N])      begin target = HALL;  door_ok = 1'b1; end
                else if (dir[DIR_S]) begin target = KEYRM; door_ok = 1'b1; end
                else if (dir[DIR_E]) begin target = GATE;  door_ok = 1'b1; end
            end
            KEYRM:  if (dir[DIR_N]) begin target = RIVER; door_ok = 1'b1; end
            GATE: begin
                if (dir[DIR_W])                 begin target = RIVER; door_ok = 1'b1; end
                else if (dir[DIR_E] && has_key) begin target = DEN;   door_ok = 1'b1; end
            end
            default: ;
        endcase
    end

    always_comb begin
        room_d  = room_q;
        lives_d = lives_q;
        moves_d = moves_q;
        case (room_q)
            DEN: begin
                if (has_sword) begin
                    room_d = WIN_RM;
                end else begin
                    room_d = GRAVE;
                    if (lives_q != '0) lives_d = lives_q - LW'(1);
                end
            end
            GRAVE:           room_d = (lives_q != '0) ? ENTRY : DEAD_RM;
            WIN_RM, DEAD_RM: room_d = room_q;
            default: begin
                if (!is_navigable(room_q)) begin
                    room_d = ENTRY;  // unused encodings recover to the start
                end else if (limit_hit) begin
                    room_d = DEAD_RM;
                end else if ($onehot(dir) && door_ok) begin
                    room_d = target;
                    if (moves_q != '1) moves_d = moves_q + MW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            room_q  <= ENTRY;
            lives_q <= LW'(LIVES);
            moves_q <= '0;
        end else begin
            room_q  <= room_d;
            lives_q <= lives_d;
            moves_q <= moves_d;
        end
    end

    item_fsm #(.GRANT_ROOM(ARMORY), .CLEAR_ON_DEATH(1'b1)) u_sword (
        .clk  (clk),
        .reset(reset),
        .room (room_q),
        .held (has_sword)
    );

    item_fsm #(.GRANT_ROOM(KEYRM), .CLEAR_ON_DEATH(1'b0)) u_key (
        .clk  (clk),
        .reset(reset),
        .room (room_q),
        .held (has_key)
    );

    assign curr_room  = room_q;
    assign lives_left = lives_q;
    assign moves      = moves_q;
    assign WIN        = (room_q == WIN_RM);
    assign DIE        = (room_q == DEAD_RM);

endmodule

// File: tb/tb_dungeon_game.sv
// Four game cores with different LIVES/MOVE_LIMIT share one input stream;
// each is compared every cycle against a table-driven model of the rules.
module tb_dungeon_game;

    localparam bit [3:0] PN = 4'b0001;
    localparam bit [3:0] PS = 4'b0010;
    localparam bit [3:0] PE = 4'b0100;
    localparam bit [3:0] PW = 4'b1000;

    localparam int LIV [4] = '{3, 1, 3, 3};
    localparam int ML  [4] = '{0, 0, 4, 20};

    typedef struct {
        int room;
        bit sword;
        bit key;
        int lives;
        int moves;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;

    logic [3:0] room_o  [4];
    logic       sword_o [4];
    logic       key_o   [4];
    logic       win_o   [4];
    logic       die_o   [4];
    logic [1:0] lives0, lives2, lives3;
    logic [0:0] lives1;
    logic [0:0] moves0, moves1;
    logic [2:0] moves2;
    logic [4:0] moves3;

    int     checks = 0;
    int     errors = 0;
    model_t mdl [4];
    int     door [6][4];

    always #5 clk = ~clk;

    dungeon_game #(.LIVES(3), .MOVE_LIMIT(0)) dut0 (
        .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
        .curr_room(room_o[0]), .has_sword(sword_o[0]), .has_key(key_o[0]),
        .lives_left(lives0), .moves(moves0), .WIN(win_o[0]), .DIE(die_o[0]));

    dungeon_game #(.LIVES(1), .MOVE_LIMIT(0)) dut1 (
        .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
        .curr_room(room_o[1]), .has_sword(sword_o[1]), .has_key(key_o[1]),
        .lives_left(lives1), .moves(moves1), .WIN(win_o[1]), .DIE(die_o[1]));

    dungeon_game #(.LIVES(3), .MOVE_LIMIT(4)) dut2 (
        .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
        .curr_room(room_o[2]), .has_sword(sword_o[2]), .has_key(key_o[2]),
        .lives_left(lives2), .moves(moves2), .WIN(win_o[2]), .DIE(die_o[2]));

    dungeon_game #(.LIVES(3), .MOVE_LIMIT(20)) dut3 (
        .clk(clk), .reset(reset), .N(n), .S(s), .E(e), .W(w),
        .curr_room(room_o[3]), .has_sword(sword_o[3]), .has_key(key_o[3]),
        .lives_left(lives3), .moves(moves3), .WIN(win_o[3]), .DIE(die_o[3]));

    // Rules of the game, one transition per clock edge.
    function automatic model_t nxt(model_t m, bit [3:0] dirs, int limit);
        model_t r = m;
        int mw, maxm, dest, idx;
        mw   = (limit == 0) ? 1 : $clog2(limit + 1);
        if (mw < 1) mw = 1;
        maxm = (1 << mw) - 1;
        if (m.room <= 5) begin
            if (limit > 0 && m.moves == limit) begin
                r.room = 9;
            end else if ($countones(dirs) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (dirs[i]) idx = i;
                dest = door[m.room][idx];
                if (m.room == 5 && idx == 2 && !m.key) dest = -1;
                if (dest >= 0) begin
                    r.room  = dest;
                    r.moves = (m.moves < maxm) ? m.moves + 1 : maxm;
                end
            end
        end else if (m.room == 6) begin
            if (m.sword) r.room = 7;
            else begin
                r.room = 8;
                if (r.lives > 0) r.lives = r.lives - 1;
            end
        end else if (m.room == 8) begin
            r.room = (m.lives > 0) ? 0 : 9;
        end
        if (m.room == 2) r.sword = 1'b1;
        if (m.room == 8) r.sword = 1'b0;
        if (m.room == 4) r.key   = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic [31:0] room, input logic [31:0] sword,
                             input logic [31:0] key, input logic [31:0] lives,
                             input logic [31:0] mv, input logic [31:0] win,
                             input logic [31:0] die);
        chk($sformatf("d%0d room", d),  room,  mdl[d].room);
        chk($sformatf("d%0d sword", d), sword, 32'(mdl[d].sword));
        chk($sformatf("d%0d key", d),   key,   32'(mdl[d].key));
        chk($sformatf("d%0d lives", d), lives, mdl[d].lives);
        chk($sformatf("d%0d moves", d), mv,    mdl[d].moves);
        chk($sformatf("d%0d WIN", d),   win,   32'(mdl[d].room == 7));
        chk($sformatf("d%0d DIE", d),   die,   32'(mdl[d].room == 9));
    endtask

    task automatic check_all();
        check_dut(0, room_o[0], sword_o[0], key_o[0], lives0, moves0, win_o[0], die_o[0]);
        check_dut(1, room_o[1], sword_o[1], key_o[1], lives1, moves1, win_o[1], die_o[1]);
        check_dut(2, room_o[2], sword_o[2], key_o[2], lives2, moves2, win_o[2], die_o[2]);
        check_dut(3, room_o[3], sword_o[3], key_o[3], lives3, moves3, win_o[3], die_o[3]);
    endtask

    task automatic reset_models();
        for (int d = 0; d < 4; d++) begin
            mdl[d].room  = 0;
            mdl[d].sword = 1'b0;
            mdl[d].key   = 1'b0;
            mdl[d].lives = LIV[d];
            mdl[d].moves = 0;
        end
    endtask

    task automatic step(input bit [3:0] dirs);
        {w, e, s, n} = dirs;
        @(posedge clk);
        for (int d = 0; d < 4; d++) mdl[d] = nxt(mdl[d], dirs, ML[d]);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {w, e, s, n} = 4'b0000;
        reset_models();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic win_path();
        step(PE); step(PN); step(PS); step(PS);
        step(PS); step(PN); step(PE); step(PE);
    endtask

    initial begin
        bit [3:0] rd;
        for (int r = 0; r < 6; r++)
            for (int d = 0; d < 4; d++) door[r][d] = -1;
        door[0][2] = 1;
        door[1][3] = 0; door[1][0] = 2; door[1][1] = 3;
        door[2][1] = 1;
        door[3][0] = 1; door[3][1] = 4; door[3][2] = 5;
        door[4][0] = 3;
        door[5][3] = 3; door[5][2] = 6;

        do_reset();

        // Winning route, then the win room must ignore arbitrary input.
        win_path();
        step(4'b0000);
        chk("win flag d0", win_o[0], 1);
        chk("win moves d3", moves3, 8);
        chk("win lives d0", lives0, 3);
        for (int i = 0; i < 10; i++) step(4'($urandom_range(0, 15)));
        chk("win hold d0", room_o[0], 7);

        // Death without the sword: respawn on 3 lives, final death on 1.
        do_reset();
        step(PE); step(PS); step(PS); step(PN); step(PE); step(PE);
        step(4'b0000);
        step(4'b0000);
        chk("respawn room d0", room_o[0], 0);
        chk("respawn lives d0", lives0, 2);
        chk("respawn key d0", key_o[0], 1);
        chk("respawn sword d0", sword_o[0], 0);
        chk("final death d1", die_o[1], 1);
        chk("final lives d1", lives1, 0);
        for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)));
        chk("dead hold d1", room_o[1], 9);

        // Locked gate, simultaneous directions, missing door.
        do_reset();
        step(PE); step(PS); step(PE);
        step(PE);
        chk("locked gate d3", room_o[3], 5);
        chk("locked moves d3", moves3, 3);
        do_reset();
        step(PE);
        step(PN | PE);
        chk("multi dir d3", room_o[3], 1);
        chk("multi moves d3", moves3, 1);
        do_reset();
        step(PW);
        chk("no door d3", room_o[3], 0);
        chk("no door moves d3", moves3, 0);

        // Move limit takes priority over a legal request.
        do_reset();
        step(PE); step(PW); step(PE); step(PW);
        chk("limit moves d2", moves2, 4);
        step(PE);
        chk("limit death d2", die_o[2], 1);

        // Asynchronous reset while in the den, then a clean replay.
        do_reset();
        win_path();
        chk("in den d0", room_o[0], 6);
        #3;
        reset = 1'b0;
        reset_models();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        win_path();
        step(4'b0000);
        chk("replay win d0", win_o[0], 1);

        // Mostly one-hot random play, restarted periodically.
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) do_reset();
            rd = 4'($urandom_range(0, 9));
            if (rd < 8) step(4'b0001 << rd[1:0]);
            else        step(4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
